seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver: accepts N_DIGITS 5-bit glyph codes and scans them one digit at a time onto a shared A–G segment bus plus per-digit enables. Loaded data is double-buffered and committed only at frame boundaries, so the display never tears. It sits between the numeric datapath and the board display pins and replaces single-digit combinational decode.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_glyph_rom.sv | 41 ++++
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph codes and A..G segment patterns (active-high).
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int         CODE_W      = 5;
    localparam logic [4:0] GLYPH_BLANK = 5'h10;
    localparam logic [4:0] GLYPH_MINUS = 5'h11;

    // Bit order: [6]=A ... [0]=G
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_rom
// Description : Combinational 5-bit glyph code to active-high A..G pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [6:0]        o_pattern
);

    always_comb begin
        o_pattern = SEG_BLANK;
        if (!i_code[4]) begin
            case (i_code[3:0])
                4'h0:    o_pattern = SEG_0;
                4'h1:    o_pattern = SEG_1;
                4'h2:    o_pattern = SEG_2;
                4'h3:    o_pattern = SEG_3;
                4'h4:    o_pattern = SEG_4;
                4'h5:    o_pattern = SEG_5;
                4'h6:    o_pattern = SEG_6;
                4'h7:    o_pattern = SEG_7;
                4'h8:    o_pattern = SEG_8;
                4'h9:    o_pattern = SEG_9;
                4'hA:    o_pattern = SEG_A;
                4'hB:    o_pattern = SEG_B;
                4'hC:    o_pattern = SEG_C;
                4'hD:    o_pattern = SEG_D;
                4'hE:    o_pattern = SEG_E;
                default: o_pattern = SEG_F;
            endcase
        end else if (i_code == GLYPH_MINUS) begin
            o_pattern = SEG_MINUS;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit seven-segment driver with frame-
//               synchronous double buffering. Define SEG7_LZB_EN for
//               leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [CODE_W*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]        dots_in,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [N_DIGITS-1:0]        an,
    output logic                       frame_done
);

    localparam int                  c_cnt_w    = $clog2(PRESCALE);
    localparam int                  c_idx_w    = $clog2(N_DIGITS);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_cnt_w-1:0]  c_blank    = c_cnt_w'(BLANK_CYC);
    localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(N_DIGITS - 1);
    localparam logic [6:0]          c_seg_inv  = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                c_dp_inv   = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] c_an_inv   = {N_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [c_cnt_w-1:0]                    r_cnt;
    logic [c_idx_w-1:0]                    r_idx;
    logic [N_DIGITS-1:0][CODE_W-1:0]       r_pend;
    logic [N_DIGITS-1:0]                   r_pend_dots;
    logic                                  r_pend_valid;
    logic [N_DIGITS-1:0][CODE_W-1:0]       r_disp;
    logic [N_DIGITS-1:0]                   r_disp_dots;
    logic [6:0]                            r_seg;
    logic                                  r_dp;
    logic [N_DIGITS-1:0]                   r_an;
    logic                                  r_frame_done;

    logic                                  w_slot_end;
    logic                                  w_wrap;
    logic                                  w_commit;
    logic [N_DIGITS-1:0]                   w_lzb_mask;
    logic [CODE_W-1:0]                     w_code;
    logic [6:0]                            w_pattern;
    logic [N_DIGITS-1:0]                   w_an_onehot;

    assign w_slot_end = (r_cnt == c_cnt_last);
    assign w_wrap     = w_slot_end && (r_idx == c_idx_last);
    assign w_commit   = w_wrap && r_pend_valid;

`ifdef SEG7_LZB_EN
    logic w_lead;

    // A digit is blanked while it and every more-significant digit is 0x00.
    always_comb begin
        w_lead     = 1'b1;
        w_lzb_mask = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_lead        = w_lead && (r_disp[i] == '0);
            w_lzb_mask[i] = w_lead;
        end
    end
`else
    assign w_lzb_mask = '0;
`endif

    assign w_code      = w_lzb_mask[r_idx] ? GLYPH_BLANK : r_disp[r_idx];
    assign w_an_onehot = (r_cnt < c_blank) ? '0 : (N_DIGITS'(1) << r_idx);

    seg7_glyph_rom u_glyph_rom (
        .i_code    (w_code),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_pend_dots  <= '0;
            r_pend_valid <= 1'b0;
            r_disp       <= {N_DIGITS{GLYPH_BLANK}};
            r_disp_dots  <= '0;
            r_seg        <= c_seg_inv;
            r_dp         <= c_dp_inv;
            r_an         <= c_an_inv;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + c_cnt_w'(1);
            if (w_slot_end) begin
                r_idx <= w_wrap ? '0 : r_idx + c_idx_w'(1);
            end

            // Commit consumes the old pending copy; a coincident load re-arms it.
            if (w_commit) begin
                r_disp       <= r_pend;
                r_disp_dots  <= r_pend_dots;
                r_pend_valid <= 1'b0;
            end
            if (load) begin
                r_pend       <= data_in;
                r_pend_dots  <= dots_in;
                r_pend_valid <= 1'b1;
            end

            r_seg        <= w_pattern ^ c_seg_inv;
            r_dp         <= r_disp_dots[r_idx] ^ c_dp_inv;
            r_an         <= w_an_onehot ^ c_an_inv;
            r_frame_done <= w_commit;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver (plain and inverted
//               polarity instances driven in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int B     = 1;
    localparam int FRAME = N * P;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load = 1'b0;
    logic [5*N-1:0] data_in = '0;
    logic [N-1:0]   dots_in = '0;

    logic [6:0]   seg_a, seg_b;
    logic         dp_a, dp_b;
    logic [N-1:0] an_a, an_b;
    logic         fd_a, fd_b;

    seg7_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dots_in(dots_in),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYC(B),
                       .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dots_in(dots_in),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         fd;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [6:0] hex_tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    function automatic logic [6:0] glyph(input int code);
        if (code < 16)       return hex_tbl[code];
        else if (code == 17) return 7'b0000001;
        else                 return 7'b0000000;
    endfunction

    // Reference model: time since reset determines slot and phase directly.
    int t = 0;
    int disp [N];
    int pend [N];
    bit ddots[N];
    bit pdots[N];
    bit pv = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int   phase, slot, top, code;
        if (rst) begin
            t  = 0;
            pv = 1'b0;
            foreach (disp[i]) begin disp[i] = 16; ddots[i] = 1'b0; end
            e = '{seg: 7'b0, dp: 1'b0, an: '0, fd: 1'b0};
        end else begin
            phase = t % P;
            slot  = (t / P) % N;
            top   = -1;
            foreach (disp[i]) if (disp[i] != 0) top = i;
            code  = (LZB && slot > 0 && slot > top) ? 16 : disp[slot];
            e.seg = glyph(code);
            e.dp  = ddots[slot];
            e.an  = (phase < B) ? '0 : N'(1) << slot;
            e.fd  = (phase == P - 1) && (slot == N - 1) && pv;
            if (e.fd) begin
                disp = pend;
                ddots = pdots;
                pv = 1'b0;
            end
            if (load) begin
                foreach (pend[i]) begin
                    pend[i]  = int'(data_in[5*i +: 5]);
                    pdots[i] = dots_in[i];
                end
                pv = 1'b1;
            end
            t++;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({seg_a, dp_a, an_a, fd_a} !== {e.seg, e.dp, e.an, e.fd}) begin
                n_fail++;
                $display("FAIL scan_pos @%0t: got seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                         $time, seg_a, dp_a, an_a, fd_a, e.seg, e.dp, e.an, e.fd);
            end
            n_cmp++;
            if ({seg_b, dp_b, an_b, fd_b} !== {~e.seg, ~e.dp, ~e.an, e.fd}) begin
                n_fail++;
                $display("FAIL scan_inv @%0t: got seg=%b dp=%b an=%b fd=%b, want seg=%b dp=%b an=%b fd=%b",
                         $time, seg_b, dp_b, an_b, fd_b, ~e.seg, ~e.dp, ~e.an, e.fd);
            end
        end
    end

    task automatic set_codes(input int d3, input int d2, input int d1, input int d0);
        data_in[4:0]   = 5'(d0);
        data_in[9:5]   = 5'(d1);
        data_in[14:10] = 5'(d2);
        data_in[19:15] = 5'(d3);
    endtask

    task automatic pulse_load;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int target);
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != target; k++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Digits 3..0 = 3,2,1,0 with a dot on digit 1
        set_codes(3, 2, 1, 0);
        dots_in = 4'b0010;
        pulse_load;
        repeat (2 * FRAME) @(negedge clk);

        // Two loads in one frame: only the last is committed
        wait_phase(0);
        set_codes(8, 8, 8, 8);
        dots_in = 4'b0000;
        pulse_load;
        repeat (3) @(negedge clk);
        set_codes(10, 10, 10, 10);
        pulse_load;
        repeat (2 * FRAME) @(negedge clk);

        // Load coincident with commit
        wait_phase(2);
        set_codes(11, 4, 9, 6);
        pulse_load;
        wait_phase(FRAME - 1);
        set_codes(17, 17, 17, 17);
        pulse_load;
        repeat (3 * FRAME) @(negedge clk);

        // Leading zeros
        set_codes(0, 0, 5, 0);
        pulse_load;
        repeat (2 * FRAME) @(negedge clk);

        // Reset in mid-frame
        wait_phase(6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (FRAME) @(negedge clk);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2500; c++) begin
            load = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < N; i++)
                data_in[5*i +: 5] = ($urandom_range(0, 9) < 4) ? 5'd0 : 5'($urandom_range(0, 31));
            dots_in = N'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
